// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock over WIDTH+1-bit
// extended operands, with a start/busy/done handshake and a held product register.
module booth_multiplier_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     x,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done
);

    localparam int EW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_n;

    logic signed [EW-1:0] m_q;
    logic signed [EW-1:0] acc_q;
    logic signed [EW-1:0] mq_q;
    logic                 q1_q;
    logic [CW-1:0]        cnt_q;

    logic signed [EW-1:0] sum_p0;
    logic signed [EW-1:0] acc_n;
    logic signed [EW-1:0] mq_n;
    logic                 q1_n;
    logic                 accept;
    logic                 last;

    // One extra bit lets the unsigned range and the most-negative operand fit exactly.
    function automatic logic signed [EW-1:0] extend(input logic [WIDTH-1:0] v,
                                                    input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    function automatic logic signed [EW-1:0] booth_add(input logic signed [EW-1:0] acc,
                                                       input logic signed [EW-1:0] m,
                                                       input logic [1:0] pair);
        logic signed [EW-1:0] r;
        r = acc;
        case (pair)
            2'b01:   r = acc + m;
            2'b10:   r = acc - m;
            default: r = acc;
        endcase
        return r;
    endfunction

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (state_q == CALC) && (cnt_q == CW'(WIDTH));

    // Booth step: add/subtract, then arithmetic shift of {A, Q, q_1}
    always_comb begin
        sum_p0 = booth_add(acc_q, m_q, {mq_q[0], q1_q});
        {acc_n, mq_n, q1_n} = {sum_p0[EW-1], sum_p0, mq_q};
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (start) state_n = CALC;
            CALC:    if (last) state_n = DONE;
            DONE:    state_n = start ? CALC : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_n;
            busy    <= (state_n == CALC);
            done    <= (state_n == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            acc_q <= '0;
            mq_q  <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
            p     <= '0;
        end else if (accept) begin
            m_q   <= extend(a, sgn);
            mq_q  <= extend(x, sgn);
            acc_q <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            acc_q <= acc_n;
            mq_q  <= mq_n;
            q1_q  <= q1_n;
            cnt_q <= cnt_q + CW'(1);
            if (last) begin
                p <= {acc_n[WIDTH-2:0], mq_n};
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed bench for booth_multiplier_seq at WIDTH=4 and WIDTH=8: vector table
// plus hand-written sequences for ignored starts, back-to-back and mid-run reset.
module tb_booth_multiplier_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start4, sgn4, busy4, done4;
    logic [3:0]  a4, x4;
    logic [7:0]  p4;
    logic        start8, sgn8, busy8, done8;
    logic [7:0]  a8, x8;
    logic [15:0] p8;

    booth_multiplier_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn4),
        .a(a4), .x(x4), .p(p4), .busy(busy4), .done(done4)
    );

    booth_multiplier_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn8),
        .a(a8), .x(x8), .p(p8), .busy(busy8), .done(done8)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          w8;
        bit          s;
        int          a;
        int          x;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic op(input bit w8, input bit s, input int av, input int xv,
                      input logic [15:0] exp, input string nm);
        int n;
        int nb;
        int w;
        w = w8 ? 8 : 4;
        @(negedge clk);
        if (w8) begin
            start8 = 1'b1; sgn8 = s; a8 = 8'(av); x8 = 8'(xv);
        end else begin
            start4 = 1'b1; sgn4 = s; a4 = 4'(av); x4 = 4'(xv);
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        n  = 0;
        nb = 0;
        while (!(w8 ? done8 : done4) && n < 20) begin
            if (w8 ? busy8 : busy4) nb++;
            n++;
            @(negedge clk);
        end
        chk({nm, "_latency"}, n, w + 1);
        chk({nm, "_busy_cycles"}, nb, w + 1);
        chk({nm, "_p"}, w8 ? p8 : {8'h00, p4}, exp);
        chk({nm, "_busy_in_done"}, w8 ? busy8 : busy4, 1'b0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, w8 ? done8 : done4, 1'b0);
    endtask

    initial begin
        int dn, nb, k, d1, d2;
        logic [7:0] pa, pb;

        tv[0]  = '{0, 1,    7,    3, 16'h0015, "s4_7x3"};
        tv[1]  = '{0, 1,    4,   -4, 16'h00F0, "s4_4xm4"};
        tv[2]  = '{0, 1,   -3,    5, 16'h00F1, "s4_m3x5"};
        tv[3]  = '{0, 1,   -5,   -6, 16'h001E, "s4_m5xm6"};
        tv[4]  = '{0, 1,   -8,   -8, 16'h0040, "s4_m8xm8"};
        tv[5]  = '{0, 0,   15,   15, 16'h00E1, "u4_15x15"};
        tv[6]  = '{0, 0,    8,    0, 16'h0000, "u4_8x0"};
        tv[7]  = '{0, 1,   -8,    7, 16'h00C8, "s4_m8x7"};
        tv[8]  = '{1, 1, -128, -128, 16'h4000, "s8_m128xm128"};
        tv[9]  = '{1, 0,  255,  255, 16'hFE01, "u8_255x255"};
        tv[10] = '{1, 1,   -1,    1, 16'hFFFF, "s8_m1x1"};
        tv[11] = '{1, 1,  100,   -3, 16'hFED4, "s8_100xm3"};

        rst_n = 1'b0;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; x4 = '0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; x8 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_p4", p4, 8'h00);
        chk("reset_busy4", busy4, 1'b0);
        chk("reset_done4", done4, 1'b0);
        chk("reset_p8", p8, 16'h0000);
        chk("reset_busy8", busy8, 1'b0);
        chk("reset_done8", done8, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            op(tv[i].w8, tv[i].s, tv[i].a, tv[i].x, tv[i].exp, tv[i].nm);
        end

        repeat (3) @(negedge clk);
        chk("hold_p8", p8, 16'hFED4);

        // Ignored starts during CALC with operands churning underneath
        @(negedge clk);
        start4 = 1'b1; sgn4 = 1'b1; a4 = 4'd7; x4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        dn = 0;
        nb = 0;
        for (k = 0; k < 15; k++) begin
            if (k == 0) chk("hold_p4_at_accept", p4, 8'hC8);
            if (done4) dn++;
            if (busy4) nb++;
            if (k >= 1 && k <= 3) begin
                start4 = 1'b1; a4 = 4'd2; x4 = 4'd2; sgn4 = ~sgn4;
            end else begin
                start4 = 1'b0; a4 = a4 + 4'd5; x4 = x4 ^ 4'hA; sgn4 = ~sgn4;
            end
            @(negedge clk);
        end
        chk("ignore_p", p4, 8'h15);
        chk("ignore_done_count", dn, 1);
        chk("ignore_busy_cycles", nb, 5);
        chk("ignore_idle_after", busy4, 1'b0);

        // Start held high: back-to-back operations
        start4 = 1'b1; sgn4 = 1'b1; a4 = 4'd3; x4 = 4'd3;
        dn = 0; d1 = -1; d2 = -1; nb = 0;
        pa = '0; pb = '0;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a4 = 4'(-2); x4 = 4'd5;
            end
            if (busy4 === done4) nb++;
            if (done4) begin
                dn++;
                if (d1 < 0) begin d1 = k; pa = p4; end
                else begin d2 = k; pb = p4; end
            end
        end
        start4 = 1'b0;
        chk("b2b_done_count", dn, 2);
        chk("b2b_first_done", d1, 6);
        chk("b2b_period", d2 - d1, 6);
        chk("b2b_p_first", pa, 8'h09);
        chk("b2b_p_second", pb, 8'hF6);
        chk("b2b_busy_not_done", nb, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of an operation
        start4 = 1'b1; sgn4 = 1'b1; a4 = 4'd7; x4 = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_p4", p4, 8'h00);
        chk("arst_busy4", busy4, 1'b0);
        chk("arst_done4", done4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        nb = 0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4) dn++;
            if (busy4) nb++;
        end
        chk("arst_no_done", dn, 0);
        chk("arst_no_busy", nb, 0);
        op(0, 1, 7, 3, 16'h0015, "arst_fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Parametrised, iterative radix-2 Booth multiplier; sequential successor to the combinational 4-bit Booth multiplier.
- Computes p = a * x for a WIDTH-bit multiplicand a and multiplier x, one Booth step per clock.
- Selects signed (two's complement) or unsigned operands per operation.
- Uses a start/done handshake; trades latency for area in datapaths wider than 4 bits.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on a rising edge where busy=0
- sgn  input  1  1 = operands signed (two's complement), 0 = unsigned; sampled with start
- a  input  WIDTH  multiplicand; sampled at accept
- x  input  WIDTH  multiplier; sampled at accept
- p  output  2*WIDTH  product register
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse when p becomes valid

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, p=0, busy=0, done=0, all internal registers cleared. Reset mid-operation aborts the operation; no done pulse is produced for it.
- States:
  - IDLE: waiting for start.
  - CALC: iterating; busy=1.
  - DONE: one cycle; done=1, busy=0.
- Transitions:
  - IDLE -> CALC on start=1.
  - CALC -> DONE after WIDTH+1 iterations.
  - DONE -> IDLE unconditionally, or DONE -> CALC if start=1 (back-to-back accept).
- Accept: a, x and sgn are latched on the accepting edge. Operands are extended internally to WIDTH+1 bits: sign-extended if sgn=1, zero-extended if sgn=0. Later changes on a, x or sgn do not affect the operation in flight.
- Datapath: accumulator A (WIDTH+1 bits), multiplier register Q (WIDTH+1 bits), appended bit q_1 (reset to 0 at accept).
- Each CALC cycle, on the pair {Q[0], q_1}:
  - 01: A = A + M
  - 10: A = A - M
  - 00 / 11: no change
  - then arithmetic right-shift of {A, Q, q_1} by 1.
  - All arithmetic is modulo 2^(WIDTH+1).
- Iteration counter runs 0..WIDTH. p is loaded from the low 2*WIDTH bits of {A, Q} on the final iteration edge.
- Latency: done=1 during the cycle that starts exactly WIDTH+1 rising edges after the accepting edge. p is valid from that cycle onward.
- Hold: p keeps its value until the final iteration of the next operation. It is not cleared at accept.
- start while busy=1 is ignored: no queueing, no restart, no effect on the current result.
- start held high continuously gives back-to-back operations with a period of WIDTH+2 cycles.
- Result range:
  - Signed: p ranges from -(2^(WIDTH-1))*(2^(WIDTH-1)-1) to 2^(2*WIDTH-2). The most-negative × most-negative case must be exact, not overflowed.
  - Unsigned: p reaches up to (2^WIDTH-1)^2.
- No X-propagation from a or x while IDLE: p, busy and done are driven only from registers.

Test Plan:
- WIDTH=4, sgn=1, sequence (7,3), (4,-4), (-3,5), (-5,-6), one start each after done -> p = 0x15, 0xF0, 0xF1, 0x1E. done asserts exactly 5 cycles after each accept; busy is high for exactly 5 cycles.
- WIDTH=4 corners: sgn=1, (-8,-8) -> p=0x40. sgn=0, (15,15) -> p=0xE1. sgn=0, (8,0) -> p=0x00. sgn=1, (-8,7) -> p=0xC8.
- WIDTH=8, sgn=1, (-128,-128) -> p=0x4000. sgn=0, (255,255) -> p=0xFE01. sgn=1, (-1,1) -> p=0xFFFF.
- WIDTH=4, accept (7,3); pulse start with (2,2) and toggle a/x/sgn during CALC -> p=0x15, a single done pulse, and no second operation starts.
- WIDTH=4, start held high with (3,3) then (-2,5) presented at each accept -> done every 6 cycles, p=0x09 then 0xF6, busy low only in the DONE cycles.
- WIDTH=4, assert rst_n=0 for one cycle in mid-CALC (iteration 2), asynchronously between edges -> p, busy and done go to 0 immediately with no done pulse afterwards; a fresh start (7,3) then gives p=0x15 with normal latency.
